// File: rtl/game_sequencer.sv
// Game-phase controller for the flappy-bird datapath, stepped on the 100 ms tick.
// Sequences idle/load/countdown/play/pause/over and tracks level, high score and active player.
module game_sequencer #(
    parameter int COUNT_TICKS = 10,
    parameter int COUNT_START = 3,
    parameter int OVER_HOLD   = 20,
    parameter int LVL1_SCORE  = 10,
    parameter int LVL2_SCORE  = 25,
    parameter int LVL3_SCORE  = 50
) (
    input  logic        clk_100ms,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        mode,
    input  logic        fail,
    input  logic [15:0] score,
    output logic        game_rst_n,
    output logic        run,
    output logic [2:0]  phase,
    output logic [1:0]  countdown,
    output logic [1:0]  level,
    output logic [15:0] high_score,
    output logic        new_record,
    output logic        player
);

    localparam int TICK_W = (COUNT_TICKS > 2) ? $clog2(COUNT_TICKS) : 1;
    localparam int HOLD_W = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(COUNT_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(OVER_HOLD);
    localparam logic [1:0]        COUNT_INIT = 2'(COUNT_START);
    localparam logic [15:0]       LVL1       = 16'(LVL1_SCORE);
    localparam logic [15:0]       LVL2       = 16'(LVL2_SCORE);
    localparam logic [15:0]       LVL3       = 16'(LVL3_SCORE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_COUNT = 3'd2,
        S_PLAY  = 3'd3,
        S_PAUSE = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t              state, state_d;
    logic [1:0]          countdown_q, countdown_d;
    logic [TICK_W-1:0]   tick_cnt, tick_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_d;
    logic [1:0]          level_q, level_d;
    logic [15:0]         high_q, high_d;
    logic                rec_q, rec_d;
    logic                player_q, player_d;
    logic                mode_q, mode_d;
    logic                start_q, pause_q;
    logic                game_rst_n_q, run_q;
    logic                start_e, pause_e;
    logic [1:0]          score_level;

    // Edge history resets high so a button held through reset release is not a press.
    assign start_e = start & ~start_q;
    assign pause_e = pause & ~pause_q;

    always_comb begin
        score_level = 2'd0;
        if (score >= LVL3)      score_level = 2'd3;
        else if (score >= LVL2) score_level = 2'd2;
        else if (score >= LVL1) score_level = 2'd1;
    end

    always_comb begin
        state_d     = state;
        countdown_d = countdown_q;
        tick_d      = tick_cnt;
        hold_d      = hold_cnt;
        level_d     = level_q;
        high_d      = high_q;
        rec_d       = rec_q;
        player_d    = player_q;
        mode_d      = mode_q;

        case (state)
            S_IDLE: begin
                if (start_e) state_d = S_LOAD;
            end
            S_LOAD: begin
                // Dropping to single-player forces player 0 for the whole round.
                mode_d      = mode;
                if (!mode) player_d = 1'b0;
                level_d     = 2'd0;
                rec_d       = 1'b0;
                countdown_d = COUNT_INIT;
                tick_d      = '0;
                state_d     = S_COUNT;
            end
            S_COUNT: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_d = '0;
                    if (countdown_q == 2'd1) begin
                        countdown_d = 2'd0;
                        state_d     = S_PLAY;
                    end else begin
                        countdown_d = countdown_q - 2'd1;
                    end
                end else begin
                    tick_d = tick_cnt + 1'b1;
                end
            end
            S_PLAY: begin
                if (score_level > level_q) level_d = score_level;
                // A collision wins over a pause press on the same tick.
                if (fail) begin
                    state_d = S_OVER;
                    hold_d  = '0;
                    if (score > high_q) begin
                        high_d = score;
                        rec_d  = 1'b1;
                    end
                end else if (pause_e) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                // Resume re-runs the countdown without restarting the datapath.
                if (pause_e) begin
                    state_d     = S_COUNT;
                    countdown_d = COUNT_INIT;
                    tick_d      = '0;
                end
            end
            S_OVER: begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_d = hold_cnt + 1'b1;
                end else if (start_e) begin
                    state_d = S_LOAD;
                    if (mode_q) player_d = ~player_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            countdown_q  <= 2'd0;
            tick_cnt     <= '0;
            hold_cnt     <= '0;
            level_q      <= 2'd0;
            high_q       <= 16'd0;
            rec_q        <= 1'b0;
            player_q     <= 1'b0;
            mode_q       <= 1'b0;
            start_q      <= 1'b1;
            pause_q      <= 1'b1;
            game_rst_n_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state        <= state_d;
            countdown_q  <= countdown_d;
            tick_cnt     <= tick_d;
            hold_cnt     <= hold_d;
            level_q      <= level_d;
            high_q       <= high_d;
            rec_q        <= rec_d;
            player_q     <= player_d;
            mode_q       <= mode_d;
            start_q      <= start;
            pause_q      <= pause;
            game_rst_n_q <= (state_d != S_IDLE) && (state_d != S_LOAD);
            run_q        <= (state_d == S_PLAY);
        end
    end

    assign phase      = state;
    assign game_rst_n = game_rst_n_q;
    assign run        = run_q;
    assign countdown  = countdown_q;
    assign level      = level_q;
    assign high_score = high_q;
    assign new_record = rec_q;
    assign player     = player_q;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-phase controller for the flappy-bird datapath, clocked on the 100 ms game tick. It sequences idle, countdown, play, pause and game-over phases. It drives the datapath's active-low restart and run enable, and schedules difficulty level from the live score. It also keeps the session high score and, in two-player mode, alternates which player flies the bird each round.

## Interface
Parameters:
- COUNT_TICKS, 10, game ticks per countdown digit (1 s).
- COUNT_START, 3, first countdown digit shown (1..3).
- OVER_HOLD, 20, ticks in OVER before start is accepted again.
- LVL1_SCORE / LVL2_SCORE / LVL3_SCORE, 10 / 25 / 50, score thresholds for levels 1/2/3.

Ports:
- clk_100ms  in  1  game tick clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  debounced start button level.
- pause  in  1  debounced pause button level.
- mode  in  1  1 = two-player, 0 = single-player; sampled only in LOAD.
- fail  in  1  collision flag from datapath.
- score  in  16  live datapath score, unsigned.
- game_rst_n  out  1  active-low restart to datapath.
- run  out  1  datapath motion enable.
- phase  out  3  IDLE=0, LOAD=1, COUNT=2, PLAY=3, PAUSE=4, OVER=5.
- countdown  out  2  digit for the display; 0 outside COUNT.
- level  out  2  difficulty level 0..3.
- high_score  out  16  best score this session.
- new_record  out  1  the last round set high_score.
- player  out  1  active player (0/1); always 0 in single-player.

## Operation
- Edge detect: start_e = start & ~start_q, pause_e = pause & ~pause_q. start_q and pause_q reset to 1, so a button held through reset release does not trigger.
- IDLE: game_rst_n=0, run=0. start_e -> LOAD.
- LOAD (one tick): game_rst_n=0. Latches mode into mode_q, clears level and new_record, loads countdown=COUNT_START and tick_cnt=0. -> COUNT.
- COUNT: game_rst_n=1, run=0. tick_cnt increments each tick.
  - At tick_cnt==COUNT_TICKS-1: tick_cnt<=0 and countdown decrements.
  - If countdown==1 at that wrap: countdown<=0 -> PLAY.
  - start_e and pause_e are ignored.
- PLAY: run=1. Each tick, level <= 3 if score>=LVL3_SCORE, 2 if >=LVL2_SCORE, 1 if >=LVL1_SCORE, else 0. level never decreases within a round.
  - fail=1 -> OVER. On that tick: if score > high_score (strict, unsigned), high_score<=score and new_record<=1. hold_cnt<=0.
  - Otherwise pause_e -> PAUSE.
  - start_e is ignored.
- PAUSE: run=0, game_rst_n=1, level held. pause_e -> COUNT with countdown=COUNT_START and tick_cnt=0; the resume does not reset the datapath. fail and start_e are ignored.
- OVER: run=0, game_rst_n=1. hold_cnt saturates at OVER_HOLD. Once hold_cnt==OVER_HOLD, start_e -> LOAD, and if mode_q==1, player toggles on that tick. start_e before the hold expires is ignored.
- fail is sampled only in PLAY. There is no path from OVER back to IDLE except reset.
- Simultaneous events in PLAY: fail and pause_e on the same tick -> OVER. fail takes precedence over pause.

## Timing
- All outputs are registered; phase and derived outputs change one tick after the triggering edge is sampled.
- Reset values:
  - phase=IDLE, game_rst_n=0, run=0, countdown=0, level=0.
  - high_score=0, new_record=0, player=0.
  - tick_cnt=0, hold_cnt=0, mode_q=0.
- game_rst_n is low for IDLE plus exactly one LOAD tick after start.
- From start_e sampled in IDLE to first run=1 is 1 + 1 + COUNT_START×COUNT_TICKS ticks: 32 with defaults.
- level reflects the score sampled one tick earlier.
- high_score and new_record update on the PLAY->OVER tick. high_score persists across rounds and is cleared only by rst.
- Asserting rst mid-round returns to IDLE immediately (asynchronous) with all reset values, including high_score.

## Test plan
- Reset, then start pulse: phase 0->1->2; countdown 3,2,1 each held 10 ticks; run=1 on the 32nd tick after the edge; game_rst_n low until the LOAD tick completes.
- In PLAY, ramp score 0->60: level becomes 1 at score 10, 2 at 25, 3 at 50, one tick later each; then drop score to 5: level stays 3.
- Round 1: fail at score 12 -> OVER, high_score=12, new_record=1. Round 2: fail at score 7 -> high_score=12, new_record=0 (cleared in LOAD).
- In OVER, start pulse at hold_cnt=5: ignored. Start pulse after 20 ticks: LOAD. With mode=1 player toggles 0->1; with mode=0 player stays 0.
- In PLAY, pause pulse -> PAUSE with run=0 and game_rst_n=1; second pause pulse -> COUNT from 3 and back to PLAY after 30 ticks with no game_rst_n pulse. fail and pause on the same PLAY tick -> OVER.
- Hold start high through rst release: no start; release then press -> LOAD. Assert rst during COUNT: phase=0 and run=0 immediately.
